// File: rtl/cdb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cdb_arbiter: round-robin Common Data Bus arbiter with a registered broadcast.
// Revision 1.0
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter  int NUM_FU = 7,
  parameter  int TAG_W  = 5,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_value,
  output logic [NUM_FU-1:0]        ack,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_value,
  output logic [IDX_W-1:0]         cdb_fu_idx
);

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
  logic [IDX_W-1:0]  cdb_idx_q, cdb_idx_d;

  logic              req_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W:0]    slot;
  logic              grant;

  // Walk upward from rr_ptr, wrapping at NUM_FU; first requester wins.
  always_comb begin
    req_found = 1'b0;
    grant_idx = '0;
    slot      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      slot = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (slot >= (IDX_W+1)'(NUM_FU)) begin
        slot = slot - (IDX_W+1)'(NUM_FU);
      end
      if (!req_found && fu_valid[slot[IDX_W-1:0]]) begin
        req_found = 1'b1;
        grant_idx = slot[IDX_W-1:0];
      end
    end
  end

  assign grant = req_found && !squash && !reset;

  always_comb begin
    ack = '0;
    if (grant) begin
      ack[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = grant;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_idx_d   = cdb_idx_q;
    if (grant) begin
      cdb_tag_d   = fu_tag[grant_idx*TAG_W +: TAG_W];
      cdb_value_d = fu_value[grant_idx*DATA_W +: DATA_W];
      cdb_idx_d   = grant_idx;
      rr_ptr_d    = (grant_idx == IDX_W'(NUM_FU-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_idx_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_idx_q   <= cdb_idx_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_tag    = cdb_tag_q;
  assign cdb_value  = cdb_value_q;
  assign cdb_fu_idx = cdb_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// Testbench for cdb_arbiter: directed scenarios plus randomized traffic
// against a round-robin reference model.
module tb_cdb_arbiter;
  localparam int N  = 7;
  localparam int TW = 5;
  localparam int DW = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              squash;
  logic [N-1:0]      fu_valid;
  logic [N*TW-1:0]   fu_tag;
  logic [N*DW-1:0]   fu_value;
  logic [N-1:0]      ack;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_value;
  logic [2:0]        cdb_fu_idx;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          m_rr;
  logic        m_cv;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_val;
  logic [2:0]  m_idx;

  cdb_arbiter #(.NUM_FU(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value),
    .ack(ack), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_fu_idx(cdb_fu_idx)
  );

  always #5 clock = ~clock;

  function automatic int exp_grant(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ack(input int g, input logic blocked);
    logic [N-1:0] one;
    one = 1;
    if (g < 0 || blocked) return '0;
    return one << g;
  endfunction

  task automatic load(input int i, input logic [TW-1:0] t, input logic [DW-1:0] v);
    fu_tag[i*TW +: TW]   = t;
    fu_value[i*DW +: DW] = v;
  endtask

  task automatic model_clear();
    m_rr = 0; m_cv = 1'b0; m_tag = '0; m_val = '0; m_idx = '0;
  endtask

  // Advance one edge and update the model from the inputs presented at it.
  task automatic apply_edge();
    int g;
    g = exp_grant(fu_valid, m_rr);
    @(posedge clock);
    if (g >= 0 && !squash && !reset) begin
      m_cv  = 1'b1;
      m_tag = fu_tag[g*TW +: TW];
      m_val = fu_value[g*DW +: DW];
      m_idx = 3'(g);
      m_rr  = (g + 1) % N;
    end else begin
      m_cv = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; squash = 1'b0; fu_valid = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1; squash = 1'b0; fu_valid = 7'h7F;
    for (int i = 0; i < N; i++) load(i, TW'(i + 1), DW'(i * 3 + 1));
    #2;
    n_cmp++;
    if (ack !== '0) begin n_err++; $display("FAIL reset_ack: got %b want 0", ack); end
    n_cmp++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_fu_idx} !== '0) begin
      n_err++;
      $display("FAIL reset_cdb: got v=%b t=%0d val=%h idx=%0d want all 0", cdb_valid, cdb_tag, cdb_value, cdb_fu_idx);
    end
    do_reset();
  endtask

  task automatic test_single();
    load(2, 5'd5, 32'hDEAD);
    fu_valid = 7'b0000100;
    #1;
    n_cmp++;
    if (ack !== 7'b0000100) begin n_err++; $display("FAIL single_ack: got %b want 0000100", ack); end
    apply_edge();
    fu_valid = '0;
    n_cmp++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 5'd5 || cdb_value !== 32'hDEAD || cdb_fu_idx !== 3'd2) begin
      n_err++;
      $display("FAIL single_cdb: got v=%b t=%0d val=%h idx=%0d want 1/5/dead/2", cdb_valid, cdb_tag, cdb_value, cdb_fu_idx);
    end
    // rr_ptr should now be 3: FU 4 beats FU 0
    fu_valid = 7'b0010001;
    #1;
    n_cmp++;
    if (ack !== 7'b0010000) begin n_err++; $display("FAIL single_rrptr: got %b want 0010000", ack); end
    fu_valid = '0;
    apply_edge();
  endtask

  task automatic test_contention();
    int order [3] = '{1, 5, -1};
    int g;
    do_reset();
    load(1, 5'd11, 32'h1111);
    load(5, 5'd21, 32'h5555);
    fu_valid = 7'b0100010;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (ack !== exp_ack(order[c], 1'b0)) begin
        n_err++; $display("FAIL contention_ack%0d: got %b want %b", c, ack, exp_ack(order[c], 1'b0));
      end
      g = exp_grant(fu_valid, m_rr);
      apply_edge();
      if (g >= 0) fu_valid[g] = 1'b0;
      n_cmp++;
      if (cdb_valid !== (order[c] >= 0) || (cdb_valid && (cdb_fu_idx !== 3'(order[c]) || cdb_tag !== m_tag))) begin
        n_err++; $display("FAIL contention_cdb%0d: got v=%b idx=%0d t=%0d want idx %0d t=%0d", c, cdb_valid, cdb_fu_idx, cdb_tag, order[c], m_tag);
      end
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < N; i++) load(i, TW'(i), DW'(32'hA000 + i));
    fu_valid = 7'h7F;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_cmp++;
      if (ack !== exp_ack(c % N, 1'b0)) begin
        n_err++; $display("FAIL fair_ack%0d: got %b want %b", c, ack, exp_ack(c % N, 1'b0));
      end
      apply_edge();
      n_cmp++;
      if (cdb_valid !== 1'b1 || cdb_fu_idx !== 3'(c % N) || cdb_tag !== m_tag || cdb_value !== m_val) begin
        n_err++; $display("FAIL fair_cdb%0d: got v=%b idx=%0d t=%0d want idx %0d t=%0d", c, cdb_valid, cdb_fu_idx, cdb_tag, c % N, m_tag);
      end
      load(c % N, TW'(c + 10), DW'(32'hB000 + c));
    end
    fu_valid = '0;
    apply_edge();
  endtask

  task automatic test_squash();
    do_reset();
    load(2, 5'd3, 32'h33);
    fu_valid = 7'b0000100;
    apply_edge();
    load(1, 5'd7, 32'h77);
    load(5, 5'd8, 32'h88);
    fu_valid = 7'b0100010;
    squash = 1'b1;
    #1;
    n_cmp++;
    if (ack !== '0) begin n_err++; $display("FAIL squash_ack: got %b want 0", ack); end
    apply_edge();
    squash = 1'b0;
    n_cmp++;
    if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL squash_cdb: got %b want 0", cdb_valid); end
    #1;
    // rr_ptr still 3, so FU 5 precedes FU 1
    n_cmp++;
    if (ack !== 7'b0100000) begin n_err++; $display("FAIL squash_rrhold: got %b want 0100000", ack); end
    fu_valid = '0;
    apply_edge();
  endtask

  task automatic test_async_reset();
    do_reset();
    load(3, 5'd17, 32'hCAFE);
    fu_valid = 7'b0001000;
    apply_edge();
    load(1, 5'd2, 32'h2);
    load(5, 5'd6, 32'h6);
    fu_valid = 7'b0100010;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_fu_idx} !== '0) begin
      n_err++;
      $display("FAIL areset_cdb: got v=%b t=%0d val=%h idx=%0d want all 0", cdb_valid, cdb_tag, cdb_value, cdb_fu_idx);
    end
    n_cmp++;
    if (ack !== '0) begin n_err++; $display("FAIL areset_ack: got %b want 0", ack); end
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (ack !== 7'b0000010) begin n_err++; $display("FAIL areset_rrptr: got %b want 0000010", ack); end
    fu_valid = '0;
    apply_edge();
  endtask

  task automatic test_idle_hold();
    do_reset();
    load(4, 5'd9, 32'h9999);
    fu_valid = 7'b0010000;
    apply_edge();
    fu_valid = '0;
    apply_edge();
    n_cmp++;
    if (cdb_valid !== 1'b0 || cdb_tag !== 5'd9 || cdb_fu_idx !== 3'd4 || cdb_value !== 32'h9999) begin
      n_err++; $display("FAIL idle_hold: got v=%b t=%0d idx=%0d want 0/9/4", cdb_valid, cdb_tag, cdb_fu_idx);
    end
    // rr_ptr holds at 5: FU 0 loses to FU 6 after wrap search
    fu_valid = 7'b1000001;
    #1;
    n_cmp++;
    if (ack !== 7'b1000000) begin n_err++; $display("FAIL idle_rrhold: got %b want 1000000", ack); end
    fu_valid = '0;
    apply_edge();
  endtask

  task automatic test_random();
    logic   pend [N];
    int     waitc [N];
    int     g;
    logic   sq;
    do_reset();
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; waitc[i] = 0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          waitc[i] = 0;
          load(i, TW'($urandom), $urandom);
        end
        fu_valid[i] = pend[i];
      end
      sq = ($urandom_range(0, 15) == 0);
      squash = sq;
      #1;
      g = exp_grant(fu_valid, m_rr);
      n_cmp++;
      if (ack !== exp_ack(g, sq)) begin
        n_err++; $display("FAIL rand_ack%0d: got %b want %b", c, ack, exp_ack(g, sq));
      end
      apply_edge();
      n_cmp++;
      if (cdb_valid !== m_cv || (m_cv && (cdb_tag !== m_tag || cdb_value !== m_val || cdb_fu_idx !== m_idx))) begin
        n_err++;
        $display("FAIL rand_cdb%0d: got v=%b t=%0d val=%h idx=%0d want v=%b t=%0d val=%h idx=%0d",
                 c, cdb_valid, cdb_tag, cdb_value, cdb_fu_idx, m_cv, m_tag, m_val, m_idx);
      end
      if (sq) begin
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
      end else begin
        if (g >= 0) begin
          n_cmp++;
          if (waitc[g] >= N) begin n_err++; $display("FAIL rand_fair: FU %0d waited %0d want < %0d", g, waitc[g], N); end
          pend[g] = 1'b0;
        end
        for (int i = 0; i < N; i++) if (pend[i]) waitc[i]++;
      end
    end
    squash = 1'b0;
    fu_valid = '0;
    apply_edge();
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; fu_valid = '0; fu_tag = '0; fu_value = '0;
    model_clear();
    @(posedge clock); #1;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_squash();
    test_async_reset();
    test_idle_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
